// File: rtl/pb_lcd_port.sv
// pb_lcd_port: PicoBlaze port-bus peripheral driving a 4-bit HD44780 LCD.
// Commands (BASE+0) and data (BASE+1) are queued in a 4-entry FIFO and sent
// as two nibble strobes with programmable setup/enable/hold/gap/exec delays.
// BASE+2 write: bit0 = irq_en. BASE+2 read: {3'b0, overflow, irq_pending,
// full, empty, busy}.
// Ports:
//   clk, reset                  - clock, async active-high reset
//   port_id, write_strobe,
//   out_port, read_strobe       - PicoBlaze port bus inputs
//   in_port                     - registered read data
//   interrupt, interrupt_ack    - level interrupt and its acknowledge
//   lcd_e, lcd_rs, lcd_rw, lcd_d - LCD pins (lcd_rw tied low)
module pb_lcd_port #(
  parameter logic [7:0]  PORT_BASE = 8'h10,
  parameter int unsigned T_SETUP   = 2,
  parameter int unsigned T_PULSE   = 12,
  parameter int unsigned T_HOLD    = 1,
  parameter int unsigned T_NIBBLE  = 50,
  parameter int unsigned T_CMD     = 2000,
  parameter int unsigned T_CLEAR   = 82000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] port_id,
  input  logic       write_strobe,
  input  logic [7:0] out_port,
  input  logic       read_strobe,
  output logic [7:0] in_port,
  output logic       interrupt,
  input  logic       interrupt_ack,
  output logic       lcd_e,
  output logic       lcd_rs,
  output logic       lcd_rw,
  output logic [3:0] lcd_d
);

  localparam int unsigned CNT_W   = 20;
  localparam int unsigned DEPTH   = 4;
  localparam int unsigned PTR_W   = 2;
  localparam int unsigned LEVEL_W = 3;

  localparam logic [7:0] ADDR_CMD  = PORT_BASE;
  localparam logic [7:0] ADDR_DATA = PORT_BASE + 8'd1;
  localparam logic [7:0] ADDR_CTRL = PORT_BASE + 8'd2;

  typedef struct packed {
    logic       rs;
    logic [7:0] data;
  } lcd_entry_t;

  typedef enum logic [3:0] {
    S_IDLE, S_SU_H, S_EN_H, S_HO_H, S_GAP, S_SU_L, S_EN_L, S_HO_L, S_WAIT
  } state_t;

  state_t             state, state_next;
  logic [CNT_W-1:0]   cnt, cnt_load;
  logic               cnt_zero;
  lcd_entry_t         sh;

  lcd_entry_t         fifo_mem [DEPTH];
  logic [PTR_W-1:0]   wr_ptr, rd_ptr;
  logic [LEVEL_W-1:0] level;
  logic               full, empty, busy;
  logic               push_req, push, pop;
  lcd_entry_t         push_entry;

  logic               irq_en, irq_pending, overflow;
  logic               irq_en_d, irq_pending_d, overflow_d;
  logic               wait_exit, irq_set, ctrl_read;
  logic [7:0]         status;

  logic               lcd_e_d, lcd_rs_d;
  logic [3:0]         lcd_d_d;

  assign lcd_rw     = 1'b0;
  assign full       = (level == LEVEL_W'(DEPTH));
  assign empty      = (level == '0);
  assign busy       = (state != S_IDLE);
  assign cnt_zero   = (cnt == '0);
  assign push_req   = write_strobe && (port_id == ADDR_CMD || port_id == ADDR_DATA);
  assign pop        = (state == S_IDLE) && !empty;
  // A pop in the same cycle frees a slot, so a push into a full queue is kept.
  assign push       = push_req && (!full || pop);
  assign push_entry = '{rs: (port_id == ADDR_DATA), data: out_port};
  assign ctrl_read  = read_strobe && (port_id == ADDR_CTRL);
  assign wait_exit  = (state == S_WAIT) && cnt_zero;
  assign irq_set    = wait_exit && empty && !push_req;
  assign status     = {3'b000, overflow, irq_pending, full, empty, busy};

  // FIFO storage (data only, no reset needed)
  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= push_entry;
  end

  // FIFO pointers and fill level
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   level <= level + LEVEL_W'(1);
        2'b01:   level <= level - LEVEL_W'(1);
        default: level <= level;
      endcase
    end
  end

  // FSM state register, delay counter and byte shift register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= S_IDLE;
      cnt   <= '0;
      sh    <= '0;
    end else begin
      state <= state_next;
      // Consecutive states always differ, so a state change means entry.
      if (state != state_next)  cnt <= cnt_load;
      else if (state != S_IDLE) cnt <= cnt - CNT_W'(1);
      if (pop) sh <= fifo_mem[rd_ptr];
    end
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:  if (!empty)  state_next = S_SU_H;
      S_SU_H:  if (cnt_zero) state_next = S_EN_H;
      S_EN_H:  if (cnt_zero) state_next = S_HO_H;
      S_HO_H:  if (cnt_zero) state_next = S_GAP;
      S_GAP:   if (cnt_zero) state_next = S_SU_L;
      S_SU_L:  if (cnt_zero) state_next = S_EN_L;
      S_EN_L:  if (cnt_zero) state_next = S_HO_L;
      S_HO_L:  if (cnt_zero) state_next = S_WAIT;
      S_WAIT:  if (cnt_zero) state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  // Counter reload for the state being entered; clear/home need the long wait
  always_comb begin
    cnt_load = '0;
    case (state_next)
      S_SU_H, S_SU_L: cnt_load = CNT_W'(T_SETUP - 1);
      S_EN_H, S_EN_L: cnt_load = CNT_W'(T_PULSE - 1);
      S_HO_H, S_HO_L: cnt_load = CNT_W'(T_HOLD - 1);
      S_GAP:          cnt_load = CNT_W'(T_NIBBLE - 1);
      S_WAIT: begin
        if (!sh.rs && (sh.data == 8'h01 || sh.data == 8'h02))
          cnt_load = CNT_W'(T_CLEAR - 1);
        else
          cnt_load = CNT_W'(T_CMD - 1);
      end
      default:        cnt_load = '0;
    endcase
  end

  // LCD pin values for the current state (registered below)
  always_comb begin
    lcd_e_d  = 1'b0;
    lcd_rs_d = 1'b0;
    lcd_d_d  = 4'h0;
    if (state != S_IDLE) lcd_rs_d = sh.rs;
    case (state)
      S_SU_H, S_HO_H: lcd_d_d = sh.data[7:4];
      S_EN_H: begin
        lcd_d_d = sh.data[7:4];
        lcd_e_d = 1'b1;
      end
      S_SU_L, S_HO_L: lcd_d_d = sh.data[3:0];
      S_EN_L: begin
        lcd_d_d = sh.data[3:0];
        lcd_e_d = 1'b1;
      end
      default: lcd_d_d = 4'h0;
    endcase
  end

  // Control/status flag next values; set beats clear on coincidence
  always_comb begin
    irq_en_d      = irq_en;
    irq_pending_d = irq_pending;
    overflow_d    = overflow;
    if (write_strobe && port_id == ADDR_CTRL) irq_en_d = out_port[0];
    if (irq_set)            irq_pending_d = 1'b1;
    else if (interrupt_ack) irq_pending_d = 1'b0;
    if (ctrl_read)          overflow_d    = 1'b0;
    if (push_req && !push)  overflow_d    = 1'b1;
  end

  // Registered flags and outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      irq_en      <= 1'b0;
      irq_pending <= 1'b0;
      overflow    <= 1'b0;
      interrupt   <= 1'b0;
      in_port     <= 8'h00;
      lcd_e       <= 1'b0;
      lcd_rs      <= 1'b0;
      lcd_d       <= 4'h0;
    end else begin
      irq_en      <= irq_en_d;
      irq_pending <= irq_pending_d;
      overflow    <= overflow_d;
      interrupt   <= irq_pending_d & irq_en_d;
      in_port     <= (port_id == ADDR_CTRL) ? status : 8'h00;
      lcd_e       <= lcd_e_d;
      lcd_rs      <= lcd_rs_d;
      lcd_d       <= lcd_d_d;
    end
  end

endmodule

// File: tb/tb_pb_lcd_port.sv
// Testbench for pb_lcd_port: directed scenarios plus random port traffic,
// checked every cycle against a timeline model of the LCD byte transfers.
module tb_pb_lcd_port;

  localparam int TS = 2, TP = 12, TH = 1, TN = 50, TC = 200, TCL = 600;
  localparam int NIB = TS + TP + TH;
  localparam logic [7:0] BASE = 8'h10;
  localparam logic [7:0] CTRL = 8'h12;

  logic       clk = 1'b0, reset = 1'b1;
  logic [7:0] port_id = CTRL, out_port = 8'h00;
  logic       write_strobe = 1'b0, read_strobe = 1'b0, interrupt_ack = 1'b0;
  logic [7:0] in_port;
  logic       interrupt, lcd_e, lcd_rs, lcd_rw;
  logic [3:0] lcd_d;

  int n_checks = 0, n_errors = 0;

  pb_lcd_port #(
    .PORT_BASE(BASE), .T_SETUP(TS), .T_PULSE(TP), .T_HOLD(TH),
    .T_NIBBLE(TN), .T_CMD(TC), .T_CLEAR(TCL)
  ) dut (
    .clk(clk), .reset(reset), .port_id(port_id), .write_strobe(write_strobe),
    .out_port(out_port), .read_strobe(read_strobe), .in_port(in_port),
    .interrupt(interrupt), .interrupt_ack(interrupt_ack), .lcd_e(lcd_e),
    .lcd_rs(lcd_rs), .lcd_rw(lcd_rw), .lcd_d(lcd_d)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [8:0] mq[$];
  bit         m_act = 0, m_en = 0, m_pend = 0, m_ovf = 0;
  int         m_off = 0;
  logic [8:0] m_cur = '0;
  logic       m_e = 0, m_rs = 0, m_int = 0;
  logic [3:0] m_d = '0;
  logic [7:0] m_in = '0;

  // total edges from pop to WAIT exit
  function automatic int byte_len(input logic [8:0] c);
    int w;
    w = (c[8] == 1'b0 && (c[7:0] == 8'h01 || c[7:0] == 8'h02)) ? TCL : TC;
    return 2 * NIB + TN + w;
  endfunction

  // {lcd_e, lcd_d} while the engine is o cycles into byte b
  function automatic logic [4:0] lcd_at(input int o, input logic [7:0] b);
    int lo;
    if (o < NIB) return {(o >= TS && o < TS + TP), b[7:4]};
    if (o < NIB + TN) return 5'h00;
    lo = o - NIB - TN;
    if (lo < NIB) return {(lo >= TS && lo < TS + TP), b[3:0]};
    return 5'h00;
  endfunction

  int         ms_sz;
  bit         ms_push, ms_pop, ms_wexit;
  logic [4:0] ms_ed;

  initial forever begin
    @(posedge clk or posedge reset);
    if (reset) begin
      mq.delete();
      m_act = 0; m_off = 0; m_cur = '0; m_en = 0; m_pend = 0; m_ovf = 0;
      m_e = 0; m_rs = 0; m_d = '0; m_in = '0; m_int = 0;
    end else begin
      ms_sz = mq.size();
      m_in  = (port_id == CTRL) ?
              {3'b000, m_ovf, m_pend, ms_sz == 4, ms_sz == 0, m_act} : 8'h00;
      if (m_act) begin
        ms_ed = lcd_at(m_off, m_cur[7:0]);
        m_e = ms_ed[4]; m_d = ms_ed[3:0]; m_rs = m_cur[8];
      end else begin
        m_e = 0; m_d = '0; m_rs = 0;
      end
      ms_push  = write_strobe && (port_id == BASE || port_id == BASE + 8'd1);
      ms_pop   = !m_act && ms_sz > 0;
      ms_wexit = m_act && (m_off == byte_len(m_cur) - 1);
      if (ms_pop) begin
        m_cur = mq.pop_front(); m_act = 1; m_off = 0;
      end else if (m_act) begin
        if (ms_wexit) m_act = 0;
        else m_off++;
      end
      if (read_strobe && port_id == CTRL) m_ovf = 0;
      if (ms_push) begin
        if (ms_sz < 4 || ms_pop) mq.push_back({port_id == BASE + 8'd1, out_port});
        else m_ovf = 1;
      end
      if (ms_wexit && ms_sz == 0 && !ms_push) m_pend = 1;
      else if (interrupt_ack) m_pend = 0;
      if (write_strobe && port_id == CTRL) m_en = out_port[0];
      m_int = m_pend & m_en;
    end
  end

  // per-cycle comparison
  initial forever begin
    @(negedge clk);
    chk("lcd_e", 32'(lcd_e), 32'(m_e));
    chk("lcd_rs", 32'(lcd_rs), 32'(m_rs));
    chk("lcd_d", 32'(lcd_d), 32'(m_d));
    chk("lcd_rw", 32'(lcd_rw), 32'(1'b0));
    chk("in_port", 32'(in_port), 32'(m_in));
    chk("interrupt", 32'(interrupt), 32'(m_int));
  end

  // LCD byte capture from enable rises
  logic       prev_e = 0;
  bit         have_hi = 0;
  logic [3:0] hi_nib = '0;
  logic [8:0] cap[$];
  int         e_rises = 0;

  initial forever begin
    @(negedge clk);
    if (reset) begin
      have_hi = 0; prev_e = 0;
    end else begin
      if (lcd_e && !prev_e) begin
        e_rises++;
        if (have_hi) begin
          cap.push_back({lcd_rs, hi_nib, lcd_d});
          have_hi = 0;
        end else begin
          hi_nib = lcd_d; have_hi = 1;
        end
      end
      prev_e = lcd_e;
    end
  end

  // ---------------- stimulus ----------------
  task automatic do_write(input logic [7:0] p, input logic [7:0] d);
    @(negedge clk);
    port_id = p; out_port = d; write_strobe = 1;
    @(negedge clk);
    write_strobe = 0; port_id = CTRL;
  endtask

  task automatic do_read(input logic [7:0] p, output logic [7:0] d);
    @(negedge clk);
    port_id = p; read_strobe = 1;
    @(negedge clk);
    read_strobe = 0; d = in_port; port_id = CTRL;
  endtask

  task automatic do_ack();
    @(negedge clk);
    interrupt_ack = 1;
    @(negedge clk);
    interrupt_ack = 0;
  endtask

  logic [7:0] st;
  int n_d3, n_d8, n_e, first_e, n_busy, n_rs, n_d4, n_d1, k_int, n_int, r0, r, thr;
  logic [8:0] exp_cap [5] = '{9'h001, 9'h1A0, 9'h1A1, 9'h1A2, 9'h1A3};

  initial begin
    // reset state
    repeat (3) @(negedge clk);
    reset = 0;
    do_read(CTRL, st);
    chk("reset_status", 32'(st), 32'h02);

    // command 0x38: nibble shape and busy length
    do_write(BASE, 8'h38);
    n_d3 = 0; n_d8 = 0; n_e = 0; first_e = -1; n_busy = 0; n_rs = 0;
    for (int k = 0; k < 400; k++) begin
      if (lcd_d == 4'h3) n_d3++;
      if (lcd_d == 4'h8) n_d8++;
      if (lcd_e) begin n_e++; if (first_e < 0) first_e = k; end
      if (in_port[0]) n_busy++;
      if (lcd_rs) n_rs++;
      @(negedge clk);
    end
    chk("cmd38_hi_cycles", 32'(n_d3), 32'd15);
    chk("cmd38_lo_cycles", 32'(n_d8), 32'd15);
    chk("cmd38_e_cycles", 32'(n_e), 32'd24);
    chk("cmd38_first_e", 32'(first_e), 32'd4);
    chk("cmd38_busy", 32'(n_busy), 32'd280);
    chk("cmd38_rs", 32'(n_rs), 32'd0);

    // clear command takes the long wait, then a data byte
    do_write(BASE, 8'h01);
    n_busy = 0;
    for (int k = 0; k < 800; k++) begin
      if (in_port[0]) n_busy++;
      @(negedge clk);
    end
    chk("clear_busy", 32'(n_busy), 32'd680);
    do_write(BASE + 8'd1, 8'h41);
    n_rs = 0; n_d4 = 0; n_d1 = 0;
    for (int k = 0; k < 400; k++) begin
      if (lcd_rs) n_rs++;
      if (lcd_d == 4'h4) n_d4++;
      if (lcd_d == 4'h1) n_d1++;
      @(negedge clk);
    end
    chk("data41_rs", 32'(n_rs), 32'd280);
    chk("data41_hi", 32'(n_d4), 32'd15);
    chk("data41_lo", 32'(n_d1), 32'd15);

    // overflow: five writes behind a clear
    do_ack();
    cap.delete();
    do_write(BASE, 8'h01);
    for (int i = 0; i < 5; i++) do_write(BASE + 8'd1, 8'hA0 + 8'(i));
    do_read(CTRL, st);
    chk("ovf_status", 32'(st), 32'h15);
    do_read(CTRL, st);
    chk("ovf_cleared", 32'(st[4]), 32'd0);
    repeat (2000) @(negedge clk);
    chk("ovf_cap_size", 32'(cap.size()), 32'd5);
    for (int i = 0; i < 5 && i < cap.size(); i++)
      chk("ovf_cap_byte", 32'(cap[i]), 32'(exp_cap[i]));

    // interrupt enable, ack and masking
    do_ack();
    do_write(CTRL, 8'h01);
    do_write(BASE + 8'd1, 8'h55);
    k_int = -1;
    for (int k = 0; k < 400 && k_int < 0; k++) begin
      if (interrupt) k_int = k;
      else @(negedge clk);
    end
    chk("irq_rise_cycle", 32'(k_int), 32'd281);
    do_ack();
    chk("irq_after_ack", 32'(interrupt), 32'd0);
    do_write(CTRL, 8'h00);
    do_write(BASE + 8'd1, 8'h66);
    n_int = 0;
    for (int k = 0; k < 400; k++) begin
      if (interrupt) n_int++;
      @(negedge clk);
    end
    chk("irq_masked", 32'(n_int), 32'd0);
    do_read(CTRL, st);
    chk("masked_status", 32'(st), 32'h0A);

    // reset during EN_L with two bytes queued
    r0 = e_rises;
    do_write(BASE + 8'd1, 8'h30);
    do_write(BASE + 8'd1, 8'h31);
    do_write(BASE + 8'd1, 8'h32);
    for (int k = 0; k < 300 && e_rises < r0 + 2; k++) @(negedge clk);
    chk("en_l_reached", 32'(e_rises - r0), 32'd2);
    chk("e_before_reset", 32'(lcd_e), 32'd1);
    #2 reset = 1;
    #1;
    chk("rst_lcd_e", 32'(lcd_e), 32'd0);
    chk("rst_lcd_d", 32'(lcd_d), 32'd0);
    chk("rst_lcd_rs", 32'(lcd_rs), 32'd0);
    chk("rst_in_port", 32'(in_port), 32'd0);
    chk("rst_interrupt", 32'(interrupt), 32'd0);
    @(negedge clk);
    @(negedge clk);
    reset = 0;
    do_read(CTRL, st);
    chk("post_rst_status", 32'(st), 32'h02);
    r0 = e_rises;
    repeat (400) @(negedge clk);
    chk("post_rst_strobes", 32'(e_rises - r0), 32'd0);

    // random traffic, alternating heavy and light write phases
    for (int i = 0; i < 12000; i++) begin
      @(negedge clk);
      write_strobe = 0; read_strobe = 0; interrupt_ack = 0;
      port_id  = 8'($urandom_range(0, 4) == 0 ? 8'h33 : 8'(32'h10 + $urandom_range(0, 2)));
      out_port = 8'($urandom);
      thr = ((i / 1500) % 2 == 0) ? 30 : 2;
      r = int'($urandom_range(0, 999));
      if (r < thr) begin
        write_strobe = 1;
        port_id = ($urandom_range(0, 1) == 0) ? BASE : BASE + 8'd1;
        if ($urandom_range(0, 3) == 0) out_port = 8'($urandom_range(1, 2));
      end else if (r < thr + 8) begin
        write_strobe = 1; port_id = CTRL;
      end else if (r < thr + 40) begin
        read_strobe = 1;
      end else if (r < thr + 50) begin
        interrupt_ack = 1;
      end
    end
    @(negedge clk);
    write_strobe = 0; read_strobe = 0; interrupt_ack = 0; port_id = CTRL;
    repeat (3500) @(negedge clk);
    do_read(CTRL, st);
    chk("drained_idle", 32'({st[2], st[1], st[0]}), 32'b010);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
